// File: rtl/alu_pkg.sv
// Shared encodings for the ALU command issuer: unit-select codes and the issue FSM states.
package alu_pkg;

   localparam logic [1:0] ALU_ARITH = 2'b00;
   localparam logic [1:0] ALU_LOGIC = 2'b01;
   localparam logic [1:0] ALU_CMP   = 2'b10;
   localparam logic [1:0] ALU_SHIFT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/alu_issue_arb_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr_i,
// searching upward and wrapping past the top client.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [PW-1:0] grant_idx_o,
   output logic          any_o
);

   logic found;

   // Upper segment [ptr..N-1] has priority over the wrapped segment [0..ptr-1]
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i] && (i >= int'(ptr_i))) begin
            grant_o[i]  = 1'b1;
            grant_idx_o = PW'(i);
            found       = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i] && (i < int'(ptr_i))) begin
            grant_o[i]  = 1'b1;
            grant_idx_o = PW'(i);
            found       = 1'b1;
         end
      end
   end

   assign any_o = found;

endmodule

// File: rtl/alu_issue_arb.sv
// Round-robin ALU command issuer: accepts one client request at a time, drives it into the
// ALU, waits the fixed result latency and returns the result on a valid/ready channel.
module alu_issue_arb
   import alu_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int N_CLIENTS = 4,
   parameter int ALU_LAT   = 1,
   parameter int ID_W      = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [N_CLIENTS-1:0]       req_valid,
   output logic [N_CLIENTS-1:0]       req_ready,
   input  logic [4*N_CLIENTS-1:0]     req_fun,
   input  logic [WIDTH*N_CLIENTS-1:0] req_a,
   input  logic [WIDTH*N_CLIENTS-1:0] req_b,
   output logic [WIDTH-1:0]           alu_a,
   output logic [WIDTH-1:0]           alu_b,
   output logic [1:0]                 alu_fun,
   output logic [1:0]                 alu_sub,
   output logic                       alu_valid,
   input  logic [WIDTH-1:0]           alu_out,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ID_W-1:0]            rsp_id,
   output logic [WIDTH-1:0]           rsp_data
);

   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   arb_state_t       state_q, state_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       fun_q, fun_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N_CLIENTS-1:0] grant;
   logic [ID_W-1:0]      grantIdx;
   logic                 grantAny;
   logic                 accept;
   logic [3:0]           selFun;
   logic [WIDTH-1:0]     selA;
   logic [WIDTH-1:0]     selB;

   rr_arbiter #(
      .N  (N_CLIENTS),
      .PW (ID_W)
   ) u_arb (
      .req_i       (req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grantIdx),
      .any_o       (grantAny)
   );

   // A request raised while reset is asserted must not see a ready
   assign accept    = (state_q == ST_IDLE) && grantAny && !RST;
   assign req_ready = accept ? grant : '0;

   always_comb begin
      selFun = '0;
      selA   = '0;
      selB   = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (grant[i]) begin
            selFun = req_fun[i*4 +: 4];
            selA   = req_a[i*WIDTH +: WIDTH];
            selB   = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      fun_d   = fun_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d     = selA;
               b_d     = selB;
               fun_d   = selFun;
               id_d    = grantIdx;
               ptr_d   = (int'(grantIdx) == N_CLIENTS - 1) ? '0 : grantIdx + ID_W'(1);
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = CNT_W'(ALU_LAT - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               data_d  = alu_out;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         fun_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         fun_q   <= fun_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   // Operand registers double as the ALU drive, so they hold between issues
   assign alu_valid = (state_q == ST_ISSUE);
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_fun   = fun_q[3:2];
   assign alu_sub   = fun_q[1:0];
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_id    = id_q;
   assign rsp_data  = data_q;

endmodule

// File: tb/tb_alu_issue_arb.sv
// Bench for alu_issue_arb: a directed vector table, multi-cycle corner sequences on LAT=1
// and LAT=3 instances, and a randomized run against a transaction-level model.
module tb_alu_issue_arb;

   localparam int W    = 16;
   localparam int N    = 4;
   localparam int IDW  = 2;
   localparam int LAT1 = 1;
   localparam int LAT3 = 3;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   logic [N-1:0]   reqValid1, reqReady1, reqValid3, reqReady3;
   logic [4*N-1:0] reqFun1, reqFun3;
   logic [W*N-1:0] reqA1, reqB1, reqA3, reqB3;
   logic [W-1:0]   aluA1, aluB1, aluOut1, rspData1;
   logic [W-1:0]   aluA3, aluB3, aluOut3, rspData3;
   logic [1:0]     aluFun1, aluSub1, aluFun3, aluSub3;
   logic           aluValid1, rspValid1, rspReady1;
   logic           aluValid3, rspValid3, rspReady3;
   logic [IDW-1:0] rspId1, rspId3;

   alu_issue_arb #(.WIDTH(W), .N_CLIENTS(N), .ALU_LAT(LAT1), .ID_W(IDW)) dut1 (
      .CLK(CLK), .RST(RST),
      .req_valid(reqValid1), .req_ready(reqReady1), .req_fun(reqFun1),
      .req_a(reqA1), .req_b(reqB1),
      .alu_a(aluA1), .alu_b(aluB1), .alu_fun(aluFun1), .alu_sub(aluSub1),
      .alu_valid(aluValid1), .alu_out(aluOut1),
      .rsp_valid(rspValid1), .rsp_ready(rspReady1), .rsp_id(rspId1), .rsp_data(rspData1)
   );

   alu_issue_arb #(.WIDTH(W), .N_CLIENTS(N), .ALU_LAT(LAT3), .ID_W(IDW)) dut3 (
      .CLK(CLK), .RST(RST),
      .req_valid(reqValid3), .req_ready(reqReady3), .req_fun(reqFun3),
      .req_a(reqA3), .req_b(reqB3),
      .alu_a(aluA3), .alu_b(aluB3), .alu_fun(aluFun3), .alu_sub(aluSub3),
      .alu_valid(aluValid3), .alu_out(aluOut3),
      .rsp_valid(rspValid3), .rsp_ready(rspReady3), .rsp_id(rspId3), .rsp_data(rspData3)
   );

   // Behavioural ALU: {unit, sub} selects the operation
   function automatic logic [W-1:0] aluModel(input logic [3:0] fun, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [W-1:0] r;
      case (fun)
         4'b0000: r = a + b;
         4'b0001: r = a - b;
         4'b0010: r = a + 16'd1;
         4'b0011: r = a - 16'd1;
         4'b0100: r = a & b;
         4'b0101: r = a | b;
         4'b0110: r = a ^ b;
         4'b0111: r = ~a;
         4'b1000: r = {15'd0, a == b};
         4'b1001: r = {15'd0, a < b};
         4'b1010: r = {15'd0, $signed(a) < $signed(b)};
         4'b1011: r = {15'd0, a > b};
         4'b1100: r = a << b[3:0];
         4'b1101: r = a >> b[3:0];
         4'b1110: r = W'($signed(a) >>> b[3:0]);
         default: r = {a[W-2:0], a[W-1]};
      endcase
      return r;
   endfunction

   // ALU latency pipes; junk values outside the valid window expose mistimed sampling
   logic [W-1:0] pipe1;
   logic [W-1:0] pipe3 [3];
   always @(posedge CLK) begin
      pipe1    <= aluValid1 ? aluModel({aluFun1, aluSub1}, aluA1, aluB1) : 16'hBAD1;
      pipe3[0] <= aluValid3 ? aluModel({aluFun3, aluSub3}, aluA3, aluB3) : 16'hBAD3;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign aluOut1 = pipe1;
   assign aluOut3 = pipe3[2];

   typedef struct {
      int         client;
      logic [3:0] fun;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] expData;
   } vec_t;

   vec_t         vecs [9];
   logic [W-1:0] opA [N];
   logic [W-1:0] opB [N];
   logic [W-1:0] expSum;
   int           gIdx, t;

   int           mPhase, mCnt, mPtr, mId, idx;
   logic [3:0]   mFun;
   logic [W-1:0] mA, mB, mData;
   logic [N-1:0] expReady, acceptedMask;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Raise a single request on the chosen instance (1 or 3)
   task automatic applyStimulus(input int dut, input int client, input logic [3:0] fun,
                                input logic [W-1:0] a, input logic [W-1:0] b);
      if (dut == 1) begin
         reqValid1                 = N'(1) << client;
         reqFun1[client*4 +: 4]    = fun;
         reqA1[client*W +: W]      = a;
         reqB1[client*W +: W]      = b;
      end else begin
         reqValid3                 = N'(1) << client;
         reqFun3[client*4 +: 4]    = fun;
         reqA3[client*W +: W]      = a;
         reqB3[client*W +: W]      = b;
      end
   endtask

   task automatic doReset();
      @(posedge CLK);
      #1;
      RST       = 1'b1;
      reqValid1 = '0; reqFun1 = '0; reqA1 = '0; reqB1 = '0; rspReady1 = 1'b1;
      reqValid3 = '0; reqFun3 = '0; reqA3 = '0; reqB3 = '0; rspReady3 = 1'b1;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{2, 4'b0000, 16'h0003, 16'h0004, 16'h0007};
      vecs[1] = '{0, 4'b0001, 16'h0010, 16'h0001, 16'h000F};
      vecs[2] = '{1, 4'b0100, 16'hF0F0, 16'h3C3C, 16'h3030};
      vecs[3] = '{3, 4'b0110, 16'hFFFF, 16'h1234, 16'hEDCB};
      vecs[4] = '{2, 4'b1001, 16'h0001, 16'h8000, 16'h0001};
      vecs[5] = '{1, 4'b1010, 16'h8000, 16'h0001, 16'h0001};
      vecs[6] = '{0, 4'b1100, 16'h0001, 16'h0004, 16'h0010};
      vecs[7] = '{3, 4'b1110, 16'h8000, 16'h0003, 16'hF000};
      vecs[8] = '{1, 4'b1111, 16'h8001, 16'h0000, 16'h0003};

      doReset();

      @(negedge CLK);
      checkOutput("rst_alu_valid", aluValid1, 0);
      checkOutput("rst_rsp_valid", rspValid1, 0);
      checkOutput("rst_alu_a", aluA1, 0);
      checkOutput("rst_alu_b", aluB1, 0);
      checkOutput("rst_alu_fun", aluFun1, 0);
      checkOutput("rst_alu_sub", aluSub1, 0);
      checkOutput("rst_rsp_id", rspId1, 0);
      checkOutput("rst_rsp_data", rspData1, 0);
      checkOutput("rst_req_ready", reqReady1, 0);
      @(posedge CLK);
      #1;

      // Directed vector table on the LAT=1 instance
      for (int v = 0; v < 9; v++) begin
         applyStimulus(1, vecs[v].client, vecs[v].fun, vecs[v].a, vecs[v].b);
         rspReady1 = 1'b1;
         @(negedge CLK);
         checkOutput("vec_req_ready", reqReady1, 32'd1 << vecs[v].client);
         @(posedge CLK);
         #1;
         reqValid1 = '0;
         @(negedge CLK);
         checkOutput("vec_alu_valid", aluValid1, 1);
         checkOutput("vec_alu_fun", aluFun1, vecs[v].fun[3:2]);
         checkOutput("vec_alu_sub", aluSub1, vecs[v].fun[1:0]);
         checkOutput("vec_alu_a", aluA1, vecs[v].a);
         checkOutput("vec_alu_b", aluB1, vecs[v].b);
         @(negedge CLK);
         checkOutput("vec_wait_rsp_valid", rspValid1, 0);
         checkOutput("vec_wait_alu_valid", aluValid1, 0);
         @(negedge CLK);
         checkOutput("vec_rsp_valid", rspValid1, 1);
         checkOutput("vec_rsp_id", rspId1, vecs[v].client);
         checkOutput("vec_rsp_data", rspData1, vecs[v].expData);
         @(posedge CLK);
         #1;
      end

      // All four clients requesting continuously from reset
      doReset();
      rspReady1 = 1'b1;
      for (int i = 0; i < N; i++) begin
         opA[i] = W'($urandom);
         opB[i] = W'($urandom);
         reqFun1[i*4 +: 4] = 4'b0000;
         reqA1[i*W +: W]   = opA[i];
         reqB1[i*W +: W]   = opB[i];
      end
      reqValid1 = '1;
      for (int g = 0; g < 5; g++) begin
         @(negedge CLK);
         checkOutput("cont_onehot", $countones(reqReady1), 1);
         gIdx = -1;
         for (int i = 0; i < N; i++) if (reqReady1[i]) gIdx = i;
         checkOutput("cont_order", gIdx, g % N);
         expSum = opA[g % N] + opB[g % N];
         @(posedge CLK);
         #1;
         opA[g % N] = W'($urandom);
         opB[g % N] = W'($urandom);
         reqA1[(g % N)*W +: W] = opA[g % N];
         reqB1[(g % N)*W +: W] = opB[g % N];
         @(negedge CLK);
         checkOutput("cont_busy_ready", reqReady1, 0);
         @(negedge CLK);
         checkOutput("cont_busy_ready", reqReady1, 0);
         @(negedge CLK);
         checkOutput("cont_busy_ready", reqReady1, 0);
         checkOutput("cont_rsp_valid", rspValid1, 1);
         checkOutput("cont_rsp_id", rspId1, g % N);
         checkOutput("cont_rsp_data", rspData1, expSum);
      end

      // Response backpressure while another client keeps requesting
      doReset();
      applyStimulus(1, 1, 4'b0001, 16'h1000, 16'h0001);
      rspReady1 = 1'b0;
      @(posedge CLK);
      #1;
      applyStimulus(1, 0, 4'b0000, 16'h0005, 16'h0006);
      t = 0;
      @(negedge CLK);
      while (!rspValid1 && t < 10) begin
         @(negedge CLK);
         t++;
      end
      checkOutput("bp_rsp_seen", rspValid1, 1);
      checkOutput("bp_rsp_id", rspId1, 1);
      checkOutput("bp_rsp_data", rspData1, 16'h0FFF);
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         checkOutput("bp_hold_valid", rspValid1, 1);
         checkOutput("bp_hold_id", rspId1, 1);
         checkOutput("bp_hold_data", rspData1, 16'h0FFF);
         checkOutput("bp_hold_ready", reqReady1, 0);
      end
      @(posedge CLK);
      #1;
      rspReady1 = 1'b1;
      @(negedge CLK);
      checkOutput("bp_release_valid", rspValid1, 1);
      @(negedge CLK);
      checkOutput("bp_done_valid", rspValid1, 0);
      checkOutput("bp_next_grant", reqReady1, 4'b0001);

      // LAT=3 shift operation
      doReset();
      applyStimulus(3, 1, 4'b1101, 16'h8001, 16'h0004);
      rspReady3 = 1'b1;
      @(negedge CLK);
      checkOutput("lat3_req_ready", reqReady3, 4'b0010);
      @(posedge CLK);
      #1;
      reqValid3 = '0;
      @(negedge CLK);
      checkOutput("lat3_alu_valid", aluValid3, 1);
      checkOutput("lat3_alu_fun", aluFun3, 2'b11);
      checkOutput("lat3_alu_sub", aluSub3, 2'b01);
      checkOutput("lat3_alu_a", aluA3, 16'h8001);
      for (int c = 2; c <= 4; c++) begin
         @(negedge CLK);
         checkOutput("lat3_wait_rsp_valid", rspValid3, 0);
         checkOutput("lat3_wait_alu_valid", aluValid3, 0);
      end
      @(negedge CLK);
      checkOutput("lat3_rsp_valid", rspValid3, 1);
      checkOutput("lat3_rsp_id", rspId3, 1);
      checkOutput("lat3_rsp_data", rspData3, 16'h0800);
      @(negedge CLK);
      checkOutput("lat3_rsp_done", rspValid3, 0);

      // Reset in the middle of WAIT, with a request raised during reset
      @(posedge CLK);
      #1;
      applyStimulus(3, 0, 4'b0000, 16'h1111, 16'h2222);
      @(negedge CLK);
      checkOutput("rstw_req_ready", reqReady3, 4'b0001);
      @(posedge CLK);
      #1;
      reqValid3 = '0;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      applyStimulus(3, 2, 4'b0000, 16'h0001, 16'h0001);
      @(negedge CLK);
      checkOutput("rstw_same_cycle_ready", reqReady3, 0);
      @(posedge CLK);
      #1;
      RST       = 1'b0;
      reqValid3 = '0;
      @(negedge CLK);
      checkOutput("rstw_alu_valid", aluValid3, 0);
      checkOutput("rstw_rsp_valid", rspValid3, 0);
      checkOutput("rstw_alu_a", aluA3, 0);
      checkOutput("rstw_alu_b", aluB3, 0);
      checkOutput("rstw_alu_fun", aluFun3, 0);
      checkOutput("rstw_alu_sub", aluSub3, 0);
      checkOutput("rstw_rsp_id", rspId3, 0);
      checkOutput("rstw_rsp_data", rspData3, 0);
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         checkOutput("rstw_no_rsp", rspValid3, 0);
         checkOutput("rstw_no_issue", aluValid3, 0);
      end
      @(posedge CLK);
      #1;
      applyStimulus(3, 3, 4'b0010, 16'h0041, 16'h0000);
      @(negedge CLK);
      checkOutput("rstw_grant3", reqReady3, 4'b1000);
      @(posedge CLK);
      #1;
      reqValid3 = '0;
      t = 0;
      @(negedge CLK);
      while (!rspValid3 && t < 10) begin
         @(negedge CLK);
         t++;
      end
      checkOutput("rstw_rsp_seen", rspValid3, 1);
      checkOutput("rstw_rsp_id", rspId3, 3);
      checkOutput("rstw_rsp_data", rspData3, 16'h0042);

      // Randomized traffic against a transaction-level model
      doReset();
      mPhase       = 0;
      mCnt         = 0;
      mPtr         = 0;
      mId          = 0;
      mFun         = '0;
      mA           = '0;
      mB           = '0;
      mData        = '0;
      acceptedMask = '0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         @(posedge CLK);
         #1;
         for (int i = 0; i < N; i++) begin
            if (!reqValid1[i] || acceptedMask[i]) begin
               reqValid1[i]      = ($urandom_range(0, 2) == 0);
               reqFun1[i*4 +: 4] = 4'($urandom);
               reqA1[i*W +: W]   = W'($urandom);
               reqB1[i*W +: W]   = W'($urandom);
            end
         end
         rspReady1 = 1'($urandom_range(0, 1));
         @(negedge CLK);
         expReady = '0;
         if (mPhase == 0) begin
            for (int k = 0; k < N; k++) begin
               idx = (mPtr + k) % N;
               if (expReady == '0 && reqValid1[idx]) expReady[idx] = 1'b1;
            end
         end
         checkOutput("rnd_req_ready", reqReady1, expReady);
         checkOutput("rnd_alu_valid", aluValid1, (mPhase == 1) && (mCnt == 0));
         checkOutput("rnd_rsp_valid", rspValid1, mPhase == 2);
         if (mPhase == 1 && mCnt == 0) begin
            checkOutput("rnd_alu_fun", {aluFun1, aluSub1}, mFun);
            checkOutput("rnd_alu_a", aluA1, mA);
            checkOutput("rnd_alu_b", aluB1, mB);
         end
         if (mPhase == 2) begin
            checkOutput("rnd_rsp_id", rspId1, mId);
            checkOutput("rnd_rsp_data", rspData1, mData);
         end
         acceptedMask = '0;
         if (mPhase == 0) begin
            if (expReady != '0) begin
               for (int i = 0; i < N; i++) if (expReady[i]) mId = i;
               mFun         = reqFun1[mId*4 +: 4];
               mA           = reqA1[mId*W +: W];
               mB           = reqB1[mId*W +: W];
               mData        = aluModel(mFun, mA, mB);
               mPtr         = (mId + 1) % N;
               mPhase       = 1;
               mCnt         = 0;
               acceptedMask = expReady;
            end
         end else if (mPhase == 1) begin
            mCnt++;
            if (mCnt == 1 + LAT1) mPhase = 2;
         end else begin
            if (rspReady1) mPhase = 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue_arb.md
# alu_issue_arb

Multi-client command issuer for the 16-bit ALU: arbitrates round-robin among N_CLIENTS requesters and encodes each accepted request onto the ALU's 2-bit `alu_fun` unit-select plus sub-function. It drives one operation into the ALU and waits the ALU's fixed result latency. It then returns the result to the originating client over a valid/ready response channel. It sits between the control/sequencing logic and ALU_TOP, and is the producer of the `alu_fun` code that the ALU's decode unit consumes.

## Interface
- WIDTH, 16, operand/result width
- N_CLIENTS, 4, number of requesters (2..8)
- ALU_LAT, 1, cycles from `alu_valid` to valid `alu_out` (1..4)
- ID_W, 2, client-id width, must be ≥ clog2(N_CLIENTS)

- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  N_CLIENTS  per-client request valid
- req_ready  out  N_CLIENTS  per-client accept, one-hot or zero
- req_fun  in  4*N_CLIENTS  per client {unit[1:0], sub[1:0]}
- req_a, req_b  in  WIDTH*N_CLIENTS  per-client operands, client i at [i*WIDTH +: WIDTH]
- alu_a, alu_b  out  WIDTH  operands to ALU
- alu_fun  out  2  unit select: 00 arith, 01 logic, 10 cmp, 11 shift
- alu_sub  out  2  sub-function within unit
- alu_valid  out  1  one-cycle issue strobe
- alu_out  in  WIDTH  ALU result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  originating client
- rsp_data  out  WIDTH  captured ALU result

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: the grant is the first asserted `req_valid` at or after `rr_ptr`, searching upward with wrap. `req_ready` is asserted only to the grant, combinationally. On handshake:
  - latch operands, fun and id
  - `rr_ptr` ← grant+1, wrapping at N_CLIENTS
  - go to ISSUE
- ISSUE: `alu_valid`=1 for exactly one cycle. `alu_a/b/fun/sub` come from the latched registers. Load the wait counter with ALU_LAT-1. Go to WAIT.
- WAIT: stay until the counter reaches 0, then sample `alu_out` into `rsp_data` and go to RESP. With ALU_LAT=1, WAIT lasts one cycle.
- RESP: `rsp_valid`=1. `rsp_id` and `rsp_data` are held stable until `rsp_ready`. On handshake go to IDLE.
- One operation in flight. `req_ready` is all-zero outside IDLE.
- `alu_a/b/fun/sub` hold their last values outside ISSUE. The ALU qualifies on `alu_valid` only.
- No requests in IDLE: stay in IDLE, `rr_ptr` unchanged.
- Unused client ids (≥ N_CLIENTS) are never granted.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0
  - `alu_valid`=0, `rsp_valid`=0
  - `alu_a/b`=0, `alu_fun`=00, `alu_sub`=00
  - `rsp_id`=0, `rsp_data`=0
- Request handshake at the end of cycle 0 gives:
  - `alu_valid` in cycle 1
  - `alu_out` sampled at the end of cycle 1+ALU_LAT
  - `rsp_valid` from cycle 2+ALU_LAT
- Response handshake at the end of cycle k makes `req_ready` possible in cycle k+1. Minimum occupancy per op is 3+ALU_LAT cycles.
- `rsp_ready` held high while entering RESP: the response completes in its first RESP cycle.
- RST in any state, including mid-WAIT: everything returns to reset values next cycle and the in-flight op is discarded with no response. A late `alu_out` is ignored.
- Request arriving on the same cycle as RST: not accepted.

## Structure
- Package `alu_pkg`:
  - `alu_fun` encodings ALU_ARITH=2'b00, ALU_LOGIC=2'b01, ALU_CMP=2'b10, ALU_SHIFT=2'b11
  - FSM state typedef
- Sub-module `rr_arbiter`: N-way round-robin grant from a request vector and `rr_ptr`, one-hot output, combinational.
- The FSM, latches and counter stay in the top.

## Test plan
- Single op, ALU_LAT=1: client 2 sends fun=0000, a=0x0003, b=0x0004, and the ALU model returns a+b.
  - `alu_valid` in cycle 1 with `alu_fun`=00.
  - Response `rsp_id`=2, `rsp_data`=0x0007 in cycle 3.
- All four clients request continuously from reset:
  - Grant order is 0, 1, 2, 3, 0.
  - `req_ready` is never asserted to two clients at once.
  - Each client's `rsp_id` matches its own operands.
- Backpressure: `rsp_ready` held low for 5 cycles in RESP.
  - `rsp_valid`, `rsp_id` and `rsp_data` stay stable.
  - `req_ready` stays 0 throughout.
  - Completes on the cycle `rsp_ready` rises.
- ALU_LAT=3, client 1 sends fun=1101 (shift), a=0x8001.
  - `rsp_data` is the model value sampled exactly 3 cycles after `alu_valid`.
  - `alu_fun`=11, `alu_sub`=01.
- RST asserted mid-WAIT:
  - All outputs return to reset values the next cycle and no response is issued.
  - The next request from client 3 is granted first, since `rr_ptr`=0 and only client 3 is requesting.
